// File: rtl/avm_mem_tester.sv
// rtl/avm_mem_tester.sv - Avalon-MM RAM self-test master: write pattern, read back, compare.
// Optional MEMTEST_LFSR_EN selects a 32-bit Galois LFSR pattern instead of seed + i.
module avm_mem_tester #(
   parameter int ADDR_W       = 15,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     length,
   input  logic [DATA_W-1:0]   seed,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [15:0]         err_count,
   output logic [ADDR_W-1:0]   err_addr,
   output logic [DATA_W-1:0]   err_data,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_read,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   input  logic                avm_waitrequest,
   input  logic [DATA_W-1:0]   avm_readdata
);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RWAIT, S_FIN} state_t;

   state_t              state, next_state;
   logic [ADDR_W:0]     idx;
   logic [ADDR_W:0]     len_r;
   logic [ADDR_W-1:0]   base_r;
   logic [DATA_W-1:0]   seed_r;
   logic [2:0]          lat_cnt;
   logic [15:0]         err_count_r;
   logic [ADDR_W-1:0]   err_addr_r;
   logic [DATA_W-1:0]   err_data_r;
   logic                pass_r;

   logic                last_word;
   logic                wr_acc;
   logic                rd_acc;
   logic                sample;
   logic                mismatch;
   logic [DATA_W-1:0]   pat;

`ifdef MEMTEST_LFSR_EN
   localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'h8020_0003);

   logic [DATA_W-1:0] lfsr_r;

   function automatic logic [DATA_W-1:0] lfsr_load(input logic [DATA_W-1:0] s);
      return (s == '0) ? DATA_W'(1) : s;
   endfunction

   function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] x);
      return (x >> 1) ^ (x[0] ? LFSR_TAPS : '0);
   endfunction

   assign pat = lfsr_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_r <= '0;
      end else begin
         case (state)
            S_IDLE:  if (start) lfsr_r <= lfsr_load(seed);
            S_WR:    if (wr_acc) lfsr_r <= last_word ? lfsr_load(seed_r) : lfsr_step(lfsr_r);
            S_RWAIT: if (sample) lfsr_r <= lfsr_step(lfsr_r);
            default: lfsr_r <= lfsr_r;
         endcase
      end
   end
`else
   assign pat = seed_r + DATA_W'(idx);
`endif

   assign last_word = (idx == len_r - (ADDR_W+1)'(1));
   assign wr_acc    = (state == S_WR) && !avm_waitrequest;
   assign rd_acc    = (state == S_RD) && !avm_waitrequest;
   assign sample    = (state == S_RWAIT) && (lat_cnt == 3'd1);
   assign mismatch  = sample && (avm_readdata != pat);

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start) next_state = (length != '0) ? S_WR : S_FIN;
         S_WR:    if (wr_acc && last_word) next_state = S_RD;
         S_RD:    if (rd_acc) next_state = S_RWAIT;
         S_RWAIT: if (sample) next_state = last_word ? S_FIN : S_RD;
         S_FIN:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         len_r       <= '0;
         base_r      <= '0;
         seed_r      <= '0;
         lat_cnt     <= '0;
         err_count_r <= '0;
         err_addr_r  <= '0;
         err_data_r  <= '0;
         pass_r      <= 1'b0;
      end else begin
         state <= next_state;
         case (state)
            S_IDLE: begin
               if (start) begin
                  pass_r <= (length == '0);
                  if (length != '0) begin
                     base_r      <= base_addr;
                     len_r       <= length;
                     seed_r      <= seed;
                     idx         <= '0;
                     err_count_r <= '0;
                     err_addr_r  <= '0;
                     err_data_r  <= '0;
                  end
               end
            end
            S_WR: begin
               if (wr_acc) idx <= last_word ? '0 : idx + (ADDR_W+1)'(1);
            end
            S_RD: begin
               if (rd_acc) lat_cnt <= 3'(READ_LATENCY);
            end
            S_RWAIT: begin
               if (sample) begin
                  if (mismatch) begin
                     if (err_count_r != 16'hFFFF) err_count_r <= err_count_r + 16'd1;
                     if (err_count_r == 16'd0) begin
                        err_addr_r <= avm_address;
                        err_data_r <= avm_readdata;
                     end
                  end
                  // pass is resolved on entry to FIN so it is valid alongside done
                  if (last_word) pass_r <= (err_count_r == 16'd0) && !mismatch;
                  else           idx    <= idx + (ADDR_W+1)'(1);
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy           = (state != S_IDLE);
   assign done           = (state == S_FIN);
   assign pass           = pass_r;
   assign err_count      = err_count_r;
   assign err_addr       = err_addr_r;
   assign err_data       = err_data_r;
   assign avm_address    = base_r + idx[ADDR_W-1:0];
   assign avm_write      = (state == S_WR);
   assign avm_read       = (state == S_RD);
   assign avm_writedata  = (state == S_WR) ? pat : '0;
   assign avm_byteenable = '1;

endmodule

// File: tb/tb_avm_mem_tester.sv
// tb/tb_avm_mem_tester.sv - scoreboard bench for avm_mem_tester with a latency-accurate RAM model.
module tb_avm_mem_tester;
   localparam int AW = 15;
   localparam int DW = 32;
`ifdef MEMTEST_LFSR_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          reset, start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic [DW-1:0] seed;
   logic          busy, done, pass;
   logic [15:0]   err_count;
   logic [AW-1:0] err_addr, avm_address;
   logic [DW-1:0] err_data, avm_writedata, avm_readdata;
   logic          avm_read, avm_write;
   logic [3:0]    avm_byteenable;
   logic          avm_waitrequest = 1'b0;

   int total = 0;
   int bad   = 0;

   avm_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .seed(seed), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .err_addr(err_addr), .err_data(err_data), .avm_address(avm_address),
      .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata)
   );

   always #5 clk = ~clk;

   // RAM model: readdata valid exactly LAT cycles after the accepting edge
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [AW:0]   rd_pipe [0:LAT-1];
   bit            corrupt_en = 1'b0;
   logic [AW-1:0] corrupt_addr = '0;

   always @(posedge clk) begin
      if (avm_write && !avm_waitrequest)
         mem[avm_address] <= (corrupt_en && avm_address == corrupt_addr) ? 32'hDEAD_BEEF : avm_writedata;
      rd_pipe[0] <= {avm_read && !avm_waitrequest, avm_address};
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end

   assign avm_readdata = rd_pipe[LAT-1][AW] ? mem[rd_pipe[LAT-1][AW-1:0]] : 32'hBAD0_0BAD;

   // Stall generator: each new request sees 0..3 waitrequest cycles in stall mode
   bit stall_mode = 1'b0;
   bit in_req     = 1'b0;
   bit acc_pend   = 1'b0;
   int stall_left = 0;

   always @(posedge clk) begin
      #1;
      if (acc_pend) in_req = 1'b0;
      if (avm_read || avm_write) begin
         if (!in_req) begin
            in_req     = 1'b1;
            stall_left = stall_mode ? int'($urandom_range(0, 3)) : 0;
         end else if (stall_left > 0) begin
            stall_left--;
         end
         avm_waitrequest = (stall_left > 0);
      end else begin
         in_req          = 1'b0;
         avm_waitrequest = 1'b0;
      end
      acc_pend = (avm_read || avm_write) && !avm_waitrequest;
   end

   logic [AW-1:0] wa_q[$], ra_q[$], ea_q[$], er_q[$];
   logic [DW-1:0] wd_q[$], ed_q[$];
   int cyc, viol, activity;
   bit tmo;
   logic done_after;

   function automatic logic [DW-1:0] pat_first(input logic [DW-1:0] s);
`ifdef MEMTEST_LFSR_EN
      return (s == 32'h0) ? 32'h1 : s;
`else
      return s;
`endif
   endfunction

   function automatic logic [DW-1:0] pat_next(input logic [DW-1:0] p);
`ifdef MEMTEST_LFSR_EN
      return {1'b0, p[31:1]} ^ (p[0] ? 32'h8020_0003 : 32'h0);
`else
      return p + 32'd1;
`endif
   endfunction

   task automatic push_expected(input logic [AW-1:0] b, input logic [AW:0] n, input logic [DW-1:0] s);
      logic [DW-1:0] p;
      ea_q.delete(); ed_q.delete(); er_q.delete();
      p = pat_first(s);
      for (int i = 0; i < int'(n); i++) begin
         ea_q.push_back(b + AW'(i));
         er_q.push_back(b + AW'(i));
         ed_q.push_back(p);
         p = pat_next(p);
      end
   endtask

   task automatic run_dut(input logic [AW-1:0] b, input logic [AW:0] n, input logic [DW-1:0] s);
      logic          prev_stall, pr, pw, fin;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      wa_q.delete(); wd_q.delete(); ra_q.delete();
      viol = 0; activity = 0; tmo = 1'b0; prev_stall = 1'b0; fin = 1'b0;
      pa = '0; pd = '0; pr = 1'b0; pw = 1'b0;
      @(negedge clk);
      base_addr = b; length = n; seed = s; start = 1'b1; cyc = 1;
      while (!fin) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (avm_read && avm_write) viol++;
         if (prev_stall && ({pa, pd, pr, pw} !== {avm_address, avm_writedata, avm_read, avm_write})) viol++;
         prev_stall = (avm_read || avm_write) && avm_waitrequest;
         pa = avm_address; pd = avm_writedata; pr = avm_read; pw = avm_write;
         if (avm_read || avm_write) activity++;
         if (avm_write && !avm_waitrequest) begin
            wa_q.push_back(avm_address);
            wd_q.push_back(avm_writedata);
         end
         if (avm_read && !avm_waitrequest) ra_q.push_back(avm_address);
         if (done) fin = 1'b1;
         if (cyc > 3000) begin tmo = 1'b1; fin = 1'b1; end
      end
      @(negedge clk);
      done_after = done;
   endtask

   task automatic test_reset();
      logic [114:0] obs;
      int wcnt, wc;
      bit seen_done;
      obs = {busy, done, pass, err_count, err_addr, err_data, avm_address, avm_read, avm_write, avm_writedata};
      total++; if (obs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", obs); end
      total++; if (avm_byteenable !== 4'hF) begin bad++; $display("FAIL reset_byteenable got=%h want=f", avm_byteenable); end
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      base_addr = 15'h0100; length = 16'd8; seed = 32'hA5A5_0000; start = 1'b1;
      wcnt = 0; wc = 0;
      while (wcnt < 5 && wc < 200) begin
         @(negedge clk); start = 1'b0; wc++;
         if (avm_write && !avm_waitrequest) wcnt++;
      end
      @(posedge clk); #2;
      total++; if (busy !== 1'b1 || avm_write !== 1'b1) begin bad++; $display("FAIL midwr_busy got=%b%b want=11", busy, avm_write); end
      reset = 1'b1;
      #1;
      obs = {busy, done, pass, err_count, err_addr, err_data, avm_address, avm_read, avm_write, avm_writedata};
      total++; if (obs !== '0) begin bad++; $display("FAIL midwr_reset_outputs got=%h want=0", obs); end
      seen_done = 1'b0;
      repeat (3) begin @(negedge clk); if (done) seen_done = 1'b1; end
      reset = 1'b0;
      repeat (2) begin @(negedge clk); if (done) seen_done = 1'b1; end
      total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL midwr_no_done got=%b want=0", seen_done); end
   endtask

   task automatic test_clean();
      logic [AW-1:0] a, ea;
      logic [DW-1:0] d, ed;
      push_expected(15'h0010, 16'd8, 32'h1000_0000);
      run_dut(15'h0010, 16'd8, 32'h1000_0000);
      total++; if (tmo) begin bad++; $display("FAIL clean_timeout got=%0d want<=3000", cyc); end
      total++; if (wa_q.size() != 8) begin bad++; $display("FAIL clean_wcount got=%0d want=8", wa_q.size()); end
      while (ea_q.size() > 0 && wa_q.size() > 0) begin
         ea = ea_q.pop_front(); ed = ed_q.pop_front(); a = wa_q.pop_front(); d = wd_q.pop_front();
         total++; if ({a, d} !== {ea, ed}) begin bad++; $display("FAIL clean_write got=%h/%h want=%h/%h", a, d, ea, ed); end
      end
      while (er_q.size() > 0 && ra_q.size() > 0) begin
         ea = er_q.pop_front(); a = ra_q.pop_front();
         total++; if (a !== ea) begin bad++; $display("FAIL clean_read_addr got=%h want=%h", a, ea); end
      end
      total++; if (cyc != 8 + 8 * (1 + LAT) + 2) begin bad++; $display("FAIL clean_cycles got=%0d want=%0d", cyc, 8 + 8 * (1 + LAT) + 2); end
      total++; if ({pass, err_count} !== {1'b1, 16'd0}) begin bad++; $display("FAIL clean_result got=%b/%h want=1/0", pass, err_count); end
      total++; if (done_after !== 1'b0) begin bad++; $display("FAIL clean_done_pulse got=%b want=0", done_after); end
   endtask

   task automatic test_corrupt();
      corrupt_en = 1'b1; corrupt_addr = 15'h0013;
      run_dut(15'h0010, 16'd8, 32'h1000_0000);
      corrupt_en = 1'b0;
      total++; if (tmo) begin bad++; $display("FAIL corrupt_timeout got=%0d want<=3000", cyc); end
      total++; if (pass !== 1'b0) begin bad++; $display("FAIL corrupt_pass got=%b want=0", pass); end
      total++; if (err_count !== 16'd1) begin bad++; $display("FAIL corrupt_count got=%h want=1", err_count); end
      total++; if (err_addr !== 15'h0013) begin bad++; $display("FAIL corrupt_addr got=%h want=0013", err_addr); end
      total++; if (err_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL corrupt_data got=%h want=deadbeef", err_data); end
   endtask

   task automatic test_zero_len();
      run_dut(15'h0020, 16'd0, 32'h1234_5678);
      total++; if (cyc != 2) begin bad++; $display("FAIL zlen_cycles got=%0d want=2", cyc); end
      total++; if (pass !== 1'b1) begin bad++; $display("FAIL zlen_pass got=%b want=1", pass); end
      total++; if (activity != 0) begin bad++; $display("FAIL zlen_bus got=%0d want=0", activity); end
      total++; if (done_after !== 1'b0) begin bad++; $display("FAIL zlen_done_pulse got=%b want=0", done_after); end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] a, ea;
      logic [DW-1:0] d, ed;
      push_expected(15'h7FFE, 16'd4, 32'h0BAD_F00D);
      run_dut(15'h7FFE, 16'd4, 32'h0BAD_F00D);
      total++; if (wa_q.size() != 4 || ra_q.size() != 4) begin bad++; $display("FAIL wrap_count got=%0d/%0d want=4/4", wa_q.size(), ra_q.size()); end
      while (ea_q.size() > 0 && wa_q.size() > 0) begin
         ea = ea_q.pop_front(); ed = ed_q.pop_front(); a = wa_q.pop_front(); d = wd_q.pop_front();
         total++; if ({a, d} !== {ea, ed}) begin bad++; $display("FAIL wrap_write got=%h/%h want=%h/%h", a, d, ea, ed); end
      end
      while (er_q.size() > 0 && ra_q.size() > 0) begin
         ea = er_q.pop_front(); a = ra_q.pop_front();
         total++; if (a !== ea) begin bad++; $display("FAIL wrap_read_addr got=%h want=%h", a, ea); end
      end
      total++; if (pass !== 1'b1) begin bad++; $display("FAIL wrap_pass got=%b want=1", pass); end
   endtask

   task automatic test_stall();
      logic [AW-1:0] a, ea;
      logic [DW-1:0] d, ed, s;
      s = $urandom;
      stall_mode = 1'b1;
      push_expected(15'h0200, 16'd16, s);
      run_dut(15'h0200, 16'd16, s);
      stall_mode = 1'b0;
      total++; if (tmo) begin bad++; $display("FAIL stall_timeout got=%0d want<=3000", cyc); end
      total++; if (viol != 0) begin bad++; $display("FAIL stall_stability got=%0d want=0", viol); end
      total++; if (wa_q.size() != 16) begin bad++; $display("FAIL stall_wcount got=%0d want=16", wa_q.size()); end
      while (ea_q.size() > 0 && wa_q.size() > 0) begin
         ea = ea_q.pop_front(); ed = ed_q.pop_front(); a = wa_q.pop_front(); d = wd_q.pop_front();
         total++; if ({a, d} !== {ea, ed}) begin bad++; $display("FAIL stall_write got=%h/%h want=%h/%h", a, d, ea, ed); end
      end
      total++; if ({pass, err_count} !== {1'b1, 16'd0}) begin bad++; $display("FAIL stall_result got=%b/%h want=1/0", pass, err_count); end
   endtask

   task automatic test_seed_zero();
      logic [DW-1:0] first_exp;
`ifdef MEMTEST_LFSR_EN
      first_exp = 32'h0000_0001;
`else
      first_exp = 32'h0000_0000;
`endif
      run_dut(15'h0040, 16'd4, 32'h0);
      total++; if (wd_q.size() == 0 || wd_q[0] !== first_exp) begin bad++; $display("FAIL seed0_first got=%h want=%h", (wd_q.size() > 0) ? wd_q[0] : 32'hx, first_exp); end
      total++; if (cyc != 4 + 4 * (1 + LAT) + 2) begin bad++; $display("FAIL seed0_cycles got=%0d want=%0d", cyc, 4 + 4 * (1 + LAT) + 2); end
      total++; if (pass !== 1'b1) begin bad++; $display("FAIL seed0_pass got=%b want=1", pass); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; seed = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_clean();
      test_corrupt();
      test_zero_len();
      test_wrap();
      test_stall();
      test_seed_zero();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/avm_mem_tester.md
Name: avm_mem_tester

Overview:
- Avalon-MM master that exercises the on-chip RAM slave from the initiator side.
- On start it writes a deterministic pattern over a word range, then reads the range back and compares each word against the regenerated pattern.
- Reports busy/done, pass/fail, mismatch count and the first failing address and data.
- Sits beside the CPU on the system interconnect for power-on and debug RAM self-test.

Parameters:
- ADDR_W, 15, word-address width of master port
- DATA_W, 32, data width; byteenable is DATA_W/8 bits, always all-ones
- READ_LATENCY, 1, fixed slave read latency in cycles (1..4) from accepted read to valid readdata

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a test when idle
- base_addr  in  ADDR_W  first word address
- length  in  ADDR_W+1  number of words to test
- seed  in  DATA_W  pattern seed
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at test end
- pass  out  1  last test result, held until next start
- err_count  out  16  mismatch count, saturating at 16'hFFFF
- err_addr  out  ADDR_W  address of first mismatch
- err_data  out  DATA_W  readdata of first mismatch
- avm_address  out  ADDR_W  master address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  DATA_W  write data
- avm_byteenable  out  DATA_W/8  constant all-ones
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  read data

Behaviour:
- Reset values: all outputs 0, except avm_byteenable all-ones. State returns to IDLE immediately from any state; a test in flight is abandoned with no done pulse.
- States: IDLE, WR, RD, RWAIT, FIN.
- IDLE:
  - start with length!=0: latch base, length and seed; clear err_count, err_addr and err_data; go to WR.
  - start with length==0: go to FIN; pass=1.
  - start while busy: ignored.
- Pattern for word index i (0..length-1): seed + i, modulo 2^DATA_W.
- Address for word i: base_addr + i, modulo 2^ADDR_W; wraps past the top of memory.
- WR:
  - Hold avm_write=1 with address and data stable while avm_waitrequest=1.
  - Advance i on the cycle where write & ~waitrequest.
  - After the last word is accepted, reset i to 0 and go to RD.
  - No idle cycle is required between writes.
- RD:
  - Assert avm_read=1, held stable while waitrequest=1.
  - On acceptance, deassert read and go to RWAIT with a latency counter loaded to READ_LATENCY.
  - One outstanding read at a time.
- RWAIT:
  - Count down; sample avm_readdata on the cycle the count reaches the data-valid point, i.e. exactly READ_LATENCY cycles after the acceptance edge.
  - Compare against the pattern for i.
  - On mismatch: increment err_count (saturating). If err_count was 0, capture err_addr and err_data.
  - Then: if i is not the last word, increment i and go to RD; otherwise go to FIN.
- FIN: done=1 for one cycle; pass = (err_count==0); go to IDLE.
- busy=1 in WR, RD, RWAIT and FIN.
- avm_read and avm_write are never asserted together.
- Both are 0 in IDLE and FIN.
- Bus throughput:
  - Total test time: length write acceptances + length × (1 + READ_LATENCY) read cycles with no stalls, + 2 cycles overhead.

Optional Feature:
- MEMTEST_LFSR_EN defined:
  - Pattern is a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, taps 32'h80200003.
  - Loaded from seed (seed==0 forced to 32'h1).
  - Stepped once per word in WR; reloaded from seed when RD starts and stepped once per compare.
  - Requires DATA_W=32.
- Undefined: incrementing pattern seed+i; no LFSR logic is synthesised.

Test Plan:
- Reset mid-WR at word 5 → all outputs 0 next cycle; no done pulse; a later start works normally.
- Clean run with base=0x0010, length=8, seed=0x1000_0000, zero-wait memory model, latency 1 → writes 0x1000_0000..0x1000_0007 to 0x10..0x17; done after 8 + 16 + 2 cycles; pass=1, err_count=0.
- Memory model corrupts word 0x13 to 0xDEAD_BEEF → pass=0, err_count=1, err_addr=0x13, err_data=0xDEAD_BEEF.
- Wrap-around with base=0x7FFE, length=4 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001; pass=1.
- Random waitrequest of 0–3 cycles → address, data and control held stable during stalls; read and write never asserted together; pass=1. Separately, length=0 → done one cycle after start, pass=1, no bus activity.
- READ_LATENCY=2 with MEMTEST_LFSR_EN defined and seed=0 → first written word 0x0000_0001; comparisons are aligned to latency 2; pass=1.
